// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU pipeline control blocks.
//   regbits_t      : 5-bit register index
//   fwd_sel_t      : ALU operand mux select (rdat / EX/MEM / MEM/WB)
//   hazard_state_t : pipeline sequencer state
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_RDAT  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALTED
  } hazard_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational ALU operand forwarding select generation.
// Inputs : rs/rt of the ID/EX instruction, write-back info of EX/MEM and MEM/WB.
// Outputs: forwarda/forwardb select for operand A/B muxes (never 2'b11).
module forwarding_unit
  import cpu_types_pkg::*;
(
  input  regbits_t rs_id_ex,
  input  regbits_t rt_id_ex,
  input  logic     regwrite_ex_mem,
  input  logic     memread_ex_mem,
  input  regbits_t wsel_ex_mem,
  input  logic     regwrite_mem_wb,
  input  regbits_t wsel_mem_wb,
  output fwd_sel_t forwarda,
  output fwd_sel_t forwardb
);

  // EX/MEM is checked first since it holds the newer value. A load still in
  // EX/MEM has no data yet, so it is never a forwarding source.
  function automatic fwd_sel_t pick(input regbits_t src);
    fwd_sel_t sel;
    sel = FWD_RDAT;
    if (regwrite_ex_mem && !memread_ex_mem && (wsel_ex_mem != '0) && (wsel_ex_mem == src))
      sel = FWD_EXMEM;
    else if (regwrite_mem_wb && (wsel_mem_wb != '0) && (wsel_mem_wb == src))
      sel = FWD_MEMWB;
    return sel;
  endfunction

  always_comb begin
    forwarda = pick(rs_id_ex);
    forwardb = pick(rt_id_ex);
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline control for the 5-stage CPU.
// Inputs : register indices / control bits from IF/ID, ID/EX, EX/MEM, MEM/WB,
//          memory handshakes (ihit, dhit), branch_taken, halt_mem_wb.
// Outputs: forwarda/forwardb, stage register enables and flushes, halted,
//          saturating stall_cycles / flush_events counters (CNT_W bits).
module hazard_forward_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic [4:0]       rs_id_ex,
  input  logic [4:0]       rt_id_ex,
  input  logic             memread_id_ex,
  input  logic [4:0]       wsel_id_ex,
  input  logic             regwrite_ex_mem,
  input  logic             memread_ex_mem,
  input  logic [4:0]       wsel_ex_mem,
  input  logic             dreq_ex_mem,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             branch_taken,
  input  logic             regwrite_mem_wb,
  input  logic [4:0]       wsel_mem_wb,
  input  logic             halt_mem_wb,
  output logic [1:0]       forwarda,
  output logic [1:0]       forwardb,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hazard_state_t state, next_state;
  fwd_sel_t      fwd_a, fwd_b;
  logic          halt_now, mem_block, load_use;
  logic          count_stall, count_flush;

  forwarding_unit u_fwd (
    .rs_id_ex        (rs_id_ex),
    .rt_id_ex        (rt_id_ex),
    .regwrite_ex_mem (regwrite_ex_mem),
    .memread_ex_mem  (memread_ex_mem),
    .wsel_ex_mem     (wsel_ex_mem),
    .regwrite_mem_wb (regwrite_mem_wb),
    .wsel_mem_wb     (wsel_mem_wb),
    .forwarda        (fwd_a),
    .forwardb        (fwd_b)
  );

  assign forwarda = fwd_a;
  assign forwardb = fwd_b;
  assign halted   = (state == HALTED);

  // Hazard conditions. MEM_WAIT keeps the freeze until dhit even if the
  // requesting instruction's dreq were to drop.
  assign halt_now  = (state == HALTED) || halt_mem_wb;
  assign mem_block = (dreq_ex_mem || (state == MEM_WAIT)) && !dhit;
  assign load_use  = memread_id_ex && (wsel_id_ex != '0) &&
                     ((wsel_id_ex == rs_if_id) || (wsel_id_ex == rt_if_id));

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = RUN;
    if (halt_now)       next_state = HALTED;
    else if (mem_block) next_state = MEM_WAIT;
  end

  // Mealy outputs. Branch is tested before load-use: the flush removes the
  // consumer, so stalling for it would only waste a cycle.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    count_flush  = 1'b0;
    if (!nRST || halt_now || mem_block) begin
      // everything held
    end else if (branch_taken) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
      count_flush = 1'b1;
    end else if (load_use) begin
      {id_ex_en, ex_mem_en, mem_wb_en} = '1;
      id_ex_flush = 1'b1;
    end else if (!ihit) begin
      {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      if_id_flush = 1'b1;
    end else begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
    end
  end

  assign count_stall = !pc_en && (state != HALTED);

  // Saturating performance counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (count_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (count_flush && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule
